// File: rtl/fetch_unit.sv
// +---------------------------------------------------------------------------+
// | fetch_unit: PC owner, imem valid/ready fetch issue, instruction buffer.  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'hBFC00000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] ALUResult,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4
);

    localparam int              c_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW      = c_AW + 1;
    localparam logic [31:0]     c_NOP     = 32'h00000013;
    localparam logic [1:0]      c_SRC_IMM = 2'b01;
    localparam logic [1:0]      c_SRC_HLD = 2'b11;
    localparam logic [c_CW:0]   c_DEPTH   = (c_CW+1)'(DEPTH);
    localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
    localparam logic [XLEN-1:0] c_ALIGN   = ~XLEN'(3);

    logic            r_run;
    logic [XLEN-1:0] r_fetch_pc;
    logic [c_CW-1:0] r_out;
    logic [c_CW-1:0] r_drop;
    logic [c_CW-1:0] r_cnt;
    logic [c_AW-1:0] r_pwp, r_prp;
    logic [c_AW-1:0] r_bwp, r_brp;
    logic [XLEN-1:0] r_ppc    [DEPTH];
    logic [XLEN-1:0] r_bpc    [DEPTH];
    logic [31:0]     r_binstr [DEPTH];

    logic            w_redirect;
    logic            w_hold;
    logic [XLEN-1:0] w_target;
    logic            w_valid;
    logic            w_pop;
    logic            w_resp;
    logic            w_keep;
    logic            w_fire;
    logic [c_CW:0]   w_occ;

    assign w_redirect = PCSrc[1] ^ PCSrc[0];
    assign w_hold     = (PCSrc == c_SRC_HLD);
    assign w_target   = ((PCSrc == c_SRC_IMM) ? PCTarget : ALUResult) & c_ALIGN;
    assign w_valid    = (r_cnt != '0);
    assign w_pop      = w_valid && instr_ready;
    // Responses with nothing outstanding are leftovers from before a reset.
    assign w_resp     = imem_resp_valid && (r_out != '0);
    assign w_keep     = w_resp && (r_drop == '0) && !w_redirect;
    // A same-cycle decode pop frees a slot, so it counts toward credit.
    assign w_occ      = {1'b0, r_out} + {1'b0, r_cnt} - (c_CW+1)'(w_pop);

    assign imem_req_valid = r_run && !w_hold && !w_redirect && (w_occ < c_DEPTH);
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign imem_addr      = r_fetch_pc & c_ALIGN;

    assign instr_valid = w_valid;
    assign Instr       = w_valid ? r_binstr[r_brp] : c_NOP;
    assign PC          = w_valid ? r_bpc[r_brp] : '0;
    assign PCPlus4     = PC + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC & c_ALIGN;
            r_out      <= '0;
            r_drop     <= '0;
            r_cnt      <= '0;
            r_pwp      <= '0;
            r_prp      <= '0;
            r_bwp      <= '0;
            r_brp      <= '0;
        end else begin
            r_run <= 1'b1;

            if (w_redirect) begin
                r_fetch_pc <= w_target;
            end else if (w_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end

            if (w_fire) begin
                r_pwp <= r_pwp + 1'b1;
            end
            if (w_resp) begin
                r_prp <= r_prp + 1'b1;
            end
            r_out <= r_out + c_CW'(w_fire) - c_CW'(w_resp);

            // Everything still in flight at a redirect belongs to the old path.
            if (w_redirect) begin
                r_drop <= r_out - c_CW'(w_resp);
            end else if (w_resp && (r_drop != '0)) begin
                r_drop <= r_drop - 1'b1;
            end

            if (w_redirect) begin
                r_cnt <= '0;
                r_bwp <= '0;
                r_brp <= '0;
            end else begin
                if (w_keep) begin
                    r_bwp <= r_bwp + 1'b1;
                end
                if (w_pop) begin
                    r_brp <= r_brp + 1'b1;
                end
                r_cnt <= r_cnt + c_CW'(w_keep) - c_CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_ppc[r_pwp] <= r_fetch_pc;
        end
        if (w_keep) begin
            r_bpc[r_bwp]    <= r_ppc[r_prp];
            r_binstr[r_bwp] <= imem_rdata;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_keep && !w_pop && (r_cnt == c_FULL)));
`endif

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode/control stage.
- Owns the program counter and issues word fetches to instruction memory over a valid/ready request plus in-order response interface.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode.
- Consumes the decoder's PCSrc selection (pc+4 / pc+imm / ALU result / hold) to redirect or stall the fetch stream.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'hBFC00000, PC loaded on reset.
- DEPTH, 2, instruction buffer entries; also the maximum number of outstanding fetches. Power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- PCSrc  in  2  00 sequential; 01 redirect to PCTarget; 10 redirect to ALUResult; 11 hold.
- PCTarget  in  XLEN  pc+imm target for branch/jal.
- ALUResult  in  XLEN  jalr target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  fetch address (current PC).
- imem_resp_valid  in  1  response valid; responses arrive in request order, at least 1 cycle after acceptance.
- imem_rdata  in  32  fetched word.
- instr_valid  out  1  buffer head valid.
- instr_ready  in  1  decode consumes head.
- Instr  out  32  head instruction; 32'h00000013 (nop) when instr_valid=0.
- PC  out  XLEN  PC of head instruction; 0 when invalid.
- PCPlus4  out  XLEN  PC+4, wraps mod 2^XLEN.

Behaviour:
- Reset (async assert, sync release) clears:
  - fetch_pc=RESET_PC, buffer count=0, outstanding=0, drop_count=0.
  - Outputs: instr_valid=0, Instr=nop, PC=0, PCPlus4=4, imem_req_valid=0.
- First request is issued in the cycle after reset release.
- Reset mid-operation abandons all in-flight fetches; late responses after release are ignored because outstanding=0.
- Request issue:
  - imem_req_valid=1 when PCSrc≠11, no redirect this cycle, and outstanding+count<DEPTH (credit check).
  - imem_addr=fetch_pc with bits[1:0]=00.
  - On handshake: push fetch_pc into the pending-PC FIFO (DEPTH entries), outstanding+1, fetch_pc+=4 (wraps).
- Response:
  - If drop_count>0: discard, drop_count−1, outstanding−1, pop pending-PC.
  - Else: push {pending PC, imem_rdata} into the buffer, outstanding−1.
  - The credit check guarantees the buffer never overflows; a push when full is an assertion failure.
- Decode handshake: head pops when instr_valid && instr_ready. Push and pop in the same cycle leave count unchanged.
- Zero-latency bypass is not provided: minimum fetch-to-decode latency is request cycle +1 (response) +1 (buffer registered).
- Redirect (PCSrc=01 or 10) takes effect at the clock edge:
  - fetch_pc ← target with [1:0] cleared; target is PCTarget for 01, ALUResult for 10.
  - Buffer flushed (count=0), so instr_valid=0 the next cycle.
  - drop_count ← outstanding − (response this cycle ? 1 : 0). No request is issued in the redirect cycle.
  - A response arriving in the redirect cycle is discarded.
  - A decode pop in the redirect cycle is permitted; the flush dominates.
  - Back-to-back redirects: each recomputes drop_count from the current outstanding count. The last target wins.
- Hold (PCSrc=11):
  - No new requests; fetch_pc frozen.
  - Responses still fill the buffer; buffer contents unchanged except for fills.
  - Decode pops still honoured.
- Empty buffer: instr_valid=0, Instr=nop.
- Full buffer: no requests issued (credit = 0).
- PC increment and targets wrap modulo 2^XLEN.

Test Plan:
- Reset release, 1-cycle memory, instr_ready=1 → addresses BFC00000, BFC00004, BFC00008 requested on consecutive cycles; first instr_valid 2 cycles after first request with PC=BFC00000, PCPlus4=BFC00004.
- instr_ready=0 for 10 cycles → exactly DEPTH (2) requests issued, imem_req_valid=0 thereafter; on release the buffer drains in order with no loss or duplicate.
- 3-cycle memory latency, 2 fetches outstanding, PCSrc=01 with PCTarget=BFC00100 → both stale responses dropped, next request to BFC00100, first delivered PC=BFC00100.
- PCSrc=10 with ALUResult=0x00000123 in the same cycle as a response → response discarded, next request address 0x00000120.
- PCSrc=11 for 4 cycles with one fetch outstanding → no new requests, outstanding response enters buffer, fetch_pc unchanged; sequential fetch resumes when PCSrc returns to 00.
- rst_n asserted mid-stream with 2 outstanding and a full buffer → instr_valid=0 immediately; after release the first request is to BFC00000 and stale responses are ignored.
